// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// State encoding, register constants and control-field widths.
package pipeline_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      FP_BUSY = 1'b1
   } hz_state_e;

   localparam logic [4:0]  REG_ZERO   = 5'd0;
   localparam int unsigned FP_LAT_DEF = 4;

   localparam int unsigned WB_W   = 2;
   localparam int unsigned M_W    = 3;
   localparam int unsigned EX_W   = 2;
   localparam int unsigned CTRL_W = WB_W + M_W + EX_W;

   // Load in EX whose destination is read by the valid ID instruction
   function automatic logic load_use_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic       valid,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return mem_read && (rd != REG_ZERO) && valid &&
             ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

endpackage

// File: rtl/hazard_fp_timer.sv
// Loadable 4-bit down-counter timing the FP execute hold.
// Counts down to zero and stops; last flags the release cycle.
module hazard_fp_timer
   import pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] cnt,
   output logic       last
);

   logic [3:0] r_cnt;

   // load has priority; otherwise decrement until zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= 4'd0;
      else if (load)
         r_cnt <= load_val;
      else if (r_cnt != 4'd0)
         r_cnt <= r_cnt - 4'd1;
   end

   assign cnt  = r_cnt;
   assign last = (r_cnt == 4'd1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller: branch flush, FP hold, load-use stall.
// Optional stall-cycle counter enabled by the STALL_PERF_EN macro.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned FP_LAT = FP_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_is_fp,
   input  logic        branch_taken,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        if_id_flush,
   output logic        id_ex_we,
   output logic        id_ex_flush,
   output logic        ex_mem_bubble,
   output logic        fp_start,
   output logic        fp_busy,
   output logic [15:0] stall_cycles
);

   localparam bit         FP_STALL = (FP_LAT > 1);
   localparam logic [3:0] LAT_M1   = 4'(FP_LAT - 1);

   hz_state_e  r_state;
   hz_state_e  w_next;
   logic       w_load;
   logic [3:0] w_cnt;
   logic       w_last;
   logic       w_lu;

   logic w_pc_we;
   logic w_if_id_we;
   logic w_if_id_flush;
   logic w_id_ex_we;
   logic w_id_ex_flush;
   logic w_ex_mem_bubble;
   logic w_fp_start;
   logic w_fp_busy;

   hazard_fp_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .load_val (LAT_M1),
      .cnt      (w_cnt),
      .last     (w_last)
   );

   assign w_lu = load_use_hit(ex_mem_read, ex_rd, id_valid,
                              id_rs, id_rt, id_uses_rt);

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= RUN;
      else
         r_state <= w_next;
   end

   // next state and pipeline controls; branch > FP > load-use
   always_comb begin
      w_next          = r_state;
      w_load          = 1'b0;
      w_pc_we         = 1'b0;
      w_if_id_we      = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_we      = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_ex_mem_bubble = 1'b0;
      w_fp_start      = 1'b0;
      w_fp_busy       = 1'b0;
      unique case (r_state)
         RUN: begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
            w_id_ex_we = 1'b1;
            if (branch_taken) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (ex_is_fp) begin
               w_fp_start = 1'b1;
               if (FP_STALL) begin
                  w_pc_we         = 1'b0;
                  w_if_id_we      = 1'b0;
                  w_id_ex_we      = 1'b0;
                  w_ex_mem_bubble = 1'b1;
                  w_fp_busy       = 1'b1;
                  w_load          = 1'b1;
                  w_next          = FP_BUSY;
               end
            end else if (w_lu) begin
               w_pc_we       = 1'b0;
               w_if_id_we    = 1'b0;
               w_id_ex_flush = 1'b1;
            end
         end
         FP_BUSY: begin
            w_fp_busy = 1'b1;
            if (w_last || (w_cnt == 4'd0)) begin
               w_pc_we    = 1'b1;
               w_if_id_we = 1'b1;
               w_id_ex_we = 1'b1;
               w_next     = RUN;
            end else begin
               w_ex_mem_bubble = 1'b1;
            end
         end
         default: w_next = RUN;
      endcase
   end

   assign pc_we         = reset & w_pc_we;
   assign if_id_we      = reset & w_if_id_we;
   assign if_id_flush   = reset & w_if_id_flush;
   assign id_ex_we      = reset & w_id_ex_we;
   assign id_ex_flush   = reset & w_id_ex_flush;
   assign ex_mem_bubble = reset & w_ex_mem_bubble;
   assign fp_start      = reset & w_fp_start;
   assign fp_busy       = reset & w_fp_busy;

`ifdef STALL_PERF_EN
   logic [15:0] r_stall;

   // saturating count of cycles with the PC held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall <= 16'd0;
      else if (!w_pc_we && (r_stall != 16'hFFFF))
         r_stall <= r_stall + 16'd1;
   end

   assign stall_cycles = r_stall;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FP_LAT = 4).
// Honours STALL_PERF_EN for the stall-cycle expectations.
module tb_pipeline_hazard_ctrl;

`ifdef STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // expected bit order: pc_we if_id_we if_id_flush id_ex_we
   //                     id_ex_flush ex_mem_bubble fp_start fp_busy
   localparam logic [7:0] E_ZERO = 8'h00;
   localparam logic [7:0] E_IDLE = 8'hD0;
   localparam logic [7:0] E_LU   = 8'h18;
   localparam logic [7:0] E_BR   = 8'hF8;
   localparam logic [7:0] E_FPS  = 8'h07;
   localparam logic [7:0] E_FRZ  = 8'h05;
   localparam logic [7:0] E_REL  = 8'hD1;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_is_fp;
   logic        branch_taken;
   logic        pc_we;
   logic        if_id_we;
   logic        if_id_flush;
   logic        id_ex_we;
   logic        id_ex_flush;
   logic        ex_mem_bubble;
   logic        fp_start;
   logic        fp_busy;
   logic [15:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;

   pipeline_hazard_ctrl #(.FP_LAT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_is_fp      (ex_is_fp),
      .branch_taken  (branch_taken),
      .pc_we         (pc_we),
      .if_id_we      (if_id_we),
      .if_id_flush   (if_id_flush),
      .id_ex_we      (id_ex_we),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_bubble (ex_mem_bubble),
      .fp_start      (fp_start),
      .fp_busy       (fp_busy),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic       idv;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic drive(input logic idv, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic mr,
                        input logic fp, input logic br);
      id_valid     = idv;
      id_rs        = rs;
      id_rt        = rt;
      id_uses_rt   = urt;
      ex_rd        = rd;
      ex_mem_read  = mr;
      ex_is_fp     = fp;
      branch_taken = br;
   endtask

   // compare the eight controls; model the stall counter alongside
   task automatic chk(input string nm, input logic [7:0] exp);
      logic [7:0] got;
      got = {pc_we, if_id_we, if_id_flush, id_ex_we,
             id_ex_flush, ex_mem_bubble, fp_start, fp_busy};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
      if (PERF && reset && !exp[7] && exp_stall < 65535)
         exp_stall++;
   endtask

   task automatic chk_stall(input string nm);
      logic [15:0] e;
      e = PERF ? 16'(exp_stall) : 16'd0;
      checks++;
      if (stall_cycles !== e) begin
         errors++;
         $display("FAIL %s: stall_cycles got %0d expected %0d",
                  nm, stall_cycles, e);
      end
   endtask

   initial begin
      vecs[0] = '{"idle",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE};
      vecs[1] = '{"lu_rs",     1'b1, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, E_LU};
      vecs[2] = '{"lu_rd0",    1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, E_IDLE};
      vecs[3] = '{"lu_rt",     1'b1, 5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, E_LU};
      vecs[4] = '{"rt_unused", 1'b1, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, E_IDLE};
      vecs[5] = '{"id_inval",  1'b0, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, E_IDLE};
      vecs[6] = '{"no_load",   1'b1, 5'd8, 5'd1, 1'b0, 5'd8, 1'b0, 1'b0, E_IDLE};
      vecs[7] = '{"br_lu",     1'b1, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b1, E_BR};
      vecs[8] = '{"br_only",   1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, E_BR};

      // reset held with an FP op pending: everything quiet
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("rst_hold%0d", i), E_ZERO);
      end
      chk_stall("rst_stall");

      // release: FP op starts on the first RUN cycle, 4-cycle occupancy
      @(negedge clk); reset = 1'b1; #1;
      chk("fp_c0", E_FPS);
      @(negedge clk); ex_is_fp = 1'b0; #1;
      chk("fp_c1", E_FRZ);
      @(negedge clk); #1;
      chk("fp_c2", E_FRZ);
      @(negedge clk); #1;
      chk("fp_rel", E_REL);
      @(negedge clk); #1;
      chk("fp_after", E_IDLE);
      chk_stall("fp_stall");

      // single-cycle hazard table
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].idv, vecs[i].rs, vecs[i].rt, vecs[i].urt,
               vecs[i].rd, vecs[i].mr, 1'b0, vecs[i].br);
         #1;
         chk(vecs[i].nm, vecs[i].exp);
      end
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("vec_idle", E_IDLE);
      chk_stall("vec_stall");

      // back-to-back FP ops: second starts right after the release
      @(negedge clk); ex_is_fp = 1'b1; #1;
      chk("b2b_c0", E_FPS);
      @(negedge clk); #1;
      chk("b2b_c1", E_FRZ);
      @(negedge clk); #1;
      chk("b2b_c2", E_FRZ);
      @(negedge clk); #1;
      chk("b2b_rel", E_REL);
      @(negedge clk); #1;
      chk("b2b_start2", E_FPS);
      @(negedge clk); ex_is_fp = 1'b0; #1;
      chk("b2b2_c1", E_FRZ);
      @(negedge clk); #1;
      chk("b2b2_c2", E_FRZ);
      @(negedge clk); #1;
      chk("b2b2_rel", E_REL);
      chk_stall("b2b_stall");

      // reset pulsed mid-hold at cnt=2
      @(negedge clk); ex_is_fp = 1'b1; #1;
      chk("mr_c0", E_FPS);
      @(negedge clk); ex_is_fp = 1'b0; #1;
      chk("mr_c1", E_FRZ);
      @(negedge clk); #1;
      chk("mr_c2", E_FRZ);
      reset = 1'b0; #1;
      exp_stall = 0;
      chk("mr_rst", E_ZERO);
      chk_stall("mr_rst_stall");
      @(negedge clk); reset = 1'b1; #1;
      chk("mr_run", E_IDLE);
      @(negedge clk); #1;
      chk("mr_run2", E_IDLE);
      chk_stall("mr_stall");

      // long load-use stall for counter saturation
      @(negedge clk);
      drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      exp_stall = 0;
      repeat (65534) @(negedge clk);
      #1;
      exp_stall = 65534;
      chk_stall("sat_fffe");
      repeat (70000 - 65534) @(negedge clk);
      #1;
      exp_stall = 65535;
      chk_stall("sat_ffff");
      chk("sat_lu", E_LU);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline with floating-point extension. Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their write-enables, flushes and bubble inserts. Resolves three hazard classes:
- taken-branch flush;
- multi-cycle FP execution hold;
- load-use stall.

Optionally counts stalled cycles for performance measurement.

## Interface
Parameters:
- FP_LAT, 4, total EX-stage occupancy in cycles of an FP instruction; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction in ID is valid
- id_rs  in  5  rs field of ID instruction
- id_rt  in  5  rt field of ID instruction
- id_uses_rt  in  1  ID instruction reads rt
- ex_rd  in  5  destination register of EX instruction (from ID/EX write_address)
- ex_mem_read  in  1  EX instruction is a load (ID/EX M field)
- ex_is_fp  in  1  EX instruction is an FP arithmetic op
- branch_taken  in  1  EX-stage branch resolved taken
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_we  out  1  ID/EX write enable
- id_ex_flush  out  1  load zero WB/M/EX control into ID/EX (bubble)
- ex_mem_bubble  out  1  load zero controls into EX/MEM
- fp_start  out  1  one-cycle start pulse to FP unit
- fp_busy  out  1  FP hold in progress
- stall_cycles  out  16  saturating stall-cycle count

## Operation
- States: RUN, FP_BUSY. 4-bit down-counter cnt.
- Outputs are combinational from state, cnt and inputs; forced to 0 while reset is low.
- Default in RUN: pc_we = if_id_we = id_ex_we = 1; all flush/bubble/pulse outputs = 0.

Priority in RUN is branch > FP > load-use:
- branch_taken=1:
  - if_id_flush=1, id_ex_flush=1, pc_we=1.
  - ex_is_fp and load-use are ignored this cycle.
- ex_is_fp=1:
  - fp_start=1.
  - If FP_LAT=1: no stall.
  - Else: pc_we = if_id_we = id_ex_we = 0, ex_mem_bubble=1, fp_busy=1, cnt<=FP_LAT-1, next state FP_BUSY.
- Load-use, when ex_mem_read && ex_rd!=0 && id_valid && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)):
  - pc_we = if_id_we = 0, id_ex_flush=1, id_ex_we=1.
  - Exactly one bubble.

FP_BUSY:
- cnt>1: front end frozen, id_ex_we=0, ex_mem_bubble=1, fp_busy=1, cnt decrements.
- cnt==1 (release cycle): all enables 1, ex_mem_bubble=0, fp_busy=1, next state RUN, cnt<=0.
- branch_taken, ex_is_fp and load-use inputs are ignored in FP_BUSY.

## Timing
- Reset low: state=RUN, cnt=0, stall_cycles=0. All outputs are 0 while reset is held.
- Load-use: exactly 1 stall cycle. The instruction stays in ID and is re-evaluated the next cycle.
- FP op: EX occupancy is exactly FP_LAT cycles.
  - fp_start fires on the first cycle only.
  - The result latches into EX/MEM on the final cycle.
  - Front end is frozen FP_LAT-1 cycles.
- Back-to-back FP ops: the release cycle advances the next FP op into EX, which starts a new FP_LAT sequence immediately.
- Reset asserted mid-FP_BUSY: immediate return to RUN. No fp_start and no release cycle after reset deasserts.
- ex_rd==0 never triggers a load-use stall.

## Configuration
- STALL_PERF_EN defined:
  - stall_cycles increments each cycle with reset high and pc_we=0.
  - Saturates at 16'hFFFF.
- STALL_PERF_EN undefined: stall_cycles is tied to 0 and no counter is synthesized. The port is always present.

## Structure
- Shared package pipeline_pkg holds:
  - the state encoding (RUN, FP_BUSY);
  - the REG_ZERO constant (5'd0);
  - the default FP_LAT;
  - the control-field widths WB=2, M=3, EX=2 used for bubble zeroing.
- One sub-module, hazard_fp_timer:
  - loadable 4-bit down-counter;
  - inputs load, load_val;
  - outputs cnt and last (cnt==1).

## Test plan
- Reset low for 3 cycles with ex_is_fp=1 -> all outputs 0 and stall_cycles=0. After release, fp_start fires on the first RUN cycle.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_valid=1 -> one cycle with pc_we=0, id_ex_flush=1, then normal flow. Repeat with ex_rd=0 -> no stall.
- FP_LAT=4, ex_is_fp=1 -> fp_start for 1 cycle, fp_busy for 4 cycles, ex_mem_bubble=1 for 3 cycles, pc_we=0 for 3 cycles. stall_cycles=3 with STALL_PERF_EN.
- branch_taken=1 with the load-use condition also true -> if_id_flush=1, id_ex_flush=1, pc_we=1, no stall.
- Reset pulsed low during FP_BUSY at cnt=2 -> state RUN, fp_busy=0 after release, no stray fp_start.
- Force 70000 stall cycles -> stall_cycles holds at 16'hFFFF (STALL_PERF_EN), or 0 without the macro.
